// File: rtl/req_dispatch.sv
// Routes one upstream four-phase request to one of N downstream responders.
// Target choice: priority override, else rotating token; unresponsive targets are marked dead.
module req_dispatch #(
    parameter int unsigned N   = 8,
    parameter int unsigned TMO = 16,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    output logic          ack_i,
    input  logic [N-1:0]  en_mask,
    input  logic [N-1:0]  prio,
    input  logic          clr_dead,
    output logic [N-1:0]  req_o,
    input  logic [N-1:0]  ack_o,
    output logic [IW-1:0] grant_idx,
    output logic [N-1:0]  dead,
    output logic          busy
);

    localparam int unsigned CW = $clog2(TMO);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          ack_i_q, ack_i_d;
    logic [N-1:0]  req_o_q, req_o_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [N-1:0]  dead_q, dead_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  elig;
    logic [N-1:0]  pelig;
    logic [IW-1:0] sel;
    logic [IW-1:0] rot;
    logic          sel_hit;

    // Target selection: lowest eligible priority target, else first eligible from the token.
    always_comb begin
        elig    = en_mask & ~dead_q;
        pelig   = elig & prio;
        sel     = '0;
        rot     = '0;
        sel_hit = 1'b0;
        if (|pelig) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!sel_hit && pelig[IW'(i)]) begin
                    sel     = IW'(i);
                    sel_hit = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                rot = IW'((32'(ptr_q) + 32'(i)) % N);
                if (!sel_hit && elig[rot]) begin
                    sel     = rot;
                    sel_hit = 1'b1;
                end
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        ack_i_d = ack_i_q;
        req_o_d = req_o_q;
        grant_d = grant_q;
        dead_d  = clr_dead ? '0 : dead_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                ack_i_d = 1'b0;
                req_o_d = '0;
                if (req_i) begin
                    state_d = SEL;
                end
            end
            SEL: begin
                ack_i_d = 1'b0;
                req_o_d = '0;
                if (|elig) begin
                    grant_d = sel;
                    cnt_d   = '0;
                    req_o_d = N'(1) << sel;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_o[grant_q]) begin
                    req_o_d = '0;
                    ack_i_d = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    // Timeout wins over a same-edge clr_dead for the timed-out bit only.
                    dead_d[grant_q] = 1'b1;
                    req_o_d         = '0;
                    state_d         = SEL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (!req_i && !ack_o[grant_q]) begin
                    ack_i_d = 1'b0;
                    state_d = IDLE;
                    ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_i_q <= 1'b0;
            req_o_q <= '0;
            grant_q <= '0;
            dead_q  <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_i_q <= ack_i_d;
            req_o_q <= req_o_d;
            grant_q <= grant_d;
            dead_q  <= dead_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack_i     = ack_i_q;
    assign req_o     = req_o_q;
    assign grant_idx = grant_q;
    assign dead      = dead_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_req_dispatch.sv
// Directed bench for req_dispatch: expected grants queued at request time, checked at ack_i.
module tb_req_dispatch;

    logic       clk;
    logic       rst;
    logic       req_i;
    logic       ack_i;
    logic [7:0] en_mask;
    logic [7:0] prio;
    logic       clr_dead;
    logic [7:0] req_o;
    logic [7:0] ack_o;
    logic [2:0] grant_idx;
    logic [7:0] dead;
    logic       busy;

    logic [7:0] resp_en;
    logic       manual;
    int         pass_cnt;
    int         fail_cnt;
    int         total_cnt;
    logic [2:0] sb_q[$];

    req_dispatch #(.N(8), .TMO(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .ack_i     (ack_i),
        .en_mask   (en_mask),
        .prio      (prio),
        .clr_dead  (clr_dead),
        .req_o     (req_o),
        .ack_o     (ack_o),
        .grant_idx (grant_idx),
        .dead      (dead),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream responders: ack one cycle after their req, drop after req drops.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!manual) ack_o = req_o & resp_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] v);
        sb_q.push_back(v);
    endtask

    task automatic pop_chk(input string tag);
        logic [2:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(tag, 32'(grant_idx), 32'(e));
        end
    endtask

    task automatic wait_ack(input logic v, input string tag);
        int n = 0;
        while (ack_i !== v && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_ack_i"}, 32'(ack_i), 32'(v));
    endtask

    task automatic wait_req(input logic [7:0] v, input string tag);
        int n = 0;
        while (req_o !== v && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_req_o"}, 32'(req_o), 32'(v));
    endtask

    task automatic wait_dead(input logic [7:0] v, input string tag);
        int n = 0;
        while (dead !== v && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_dead"}, 32'(dead), 32'(v));
    endtask

    task automatic txn(input logic [2:0] exp, input string tag);
        push_exp(exp);
        req_i = 1'b1;
        wait_ack(1'b1, tag);
        pop_chk({tag, "_grant"});
        chk({tag, "_req_o_done"}, 32'(req_o), 32'h0);
        req_i = 1'b0;
        wait_ack(1'b0, {tag, "_rel"});
        chk({tag, "_busy_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int n;
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        req_i     = 1'b0;
        en_mask   = 8'hFF;
        prio      = 8'h00;
        clr_dead  = 1'b0;
        ack_o     = 8'h00;
        resp_en   = 8'hFF;
        manual    = 1'b0;

        tick();
        tick();
        chk("rst_ack_i", 32'(ack_i), 32'h0);
        chk("rst_req_o", 32'(req_o), 32'h0);
        chk("rst_grant", 32'(grant_idx), 32'h0);
        chk("rst_dead", 32'(dead), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Round-robin from token 0 with latency and ack hold checks on the first.
        push_exp(3'd0);
        req_i = 1'b1;
        tick();
        chk("t1_busy_sel", 32'(busy), 32'h1);
        tick();
        chk("t1_lat_req_o", 32'(req_o), 32'h01);
        chk("t1_lat_ack_i", 32'(ack_i), 32'h0);
        wait_ack(1'b1, "t1");
        pop_chk("t1_grant");
        tick();
        tick();
        chk("t1_ack_hold", 32'(ack_i), 32'h1);
        req_i = 1'b0;
        wait_ack(1'b0, "t1_rel");
        txn(3'd1, "rr1");
        txn(3'd2, "rr2");
        txn(3'd3, "rr3");

        // Priority override beats the token, then token resumes after the priority grant.
        prio = 8'h20;
        txn(3'd5, "prio");
        prio = 8'h00;
        txn(3'd6, "after_prio");
        txn(3'd7, "rr7");
        txn(3'd0, "wrap0");
        txn(3'd1, "rr1b");
        txn(3'd2, "rr2b");

        // Target 3 silent: req held exactly TMO cycles, marked dead, retry on 4.
        resp_en = 8'hF7;
        push_exp(3'd4);
        req_i = 1'b1;
        tick();
        tick();
        chk("tmo_req_o", 32'(req_o), 32'h08);
        n = 0;
        while (req_o === 8'h08 && n < 100) begin
            n++;
            tick();
        end
        chk("tmo_len", 32'(n), 32'd16);
        chk("tmo_dead", 32'(dead), 32'h08);
        wait_ack(1'b1, "tmo_retry");
        pop_chk("tmo_grant");
        req_i = 1'b0;
        wait_ack(1'b0, "tmo_rel");
        resp_en = 8'hFF;

        // Nothing eligible: park in SEL until en_mask opens a target.
        en_mask = 8'h00;
        push_exp(3'd6);
        req_i = 1'b1;
        repeat (5) tick();
        chk("noelig_req_o", 32'(req_o), 32'h0);
        chk("noelig_busy", 32'(busy), 32'h1);
        chk("noelig_ack_i", 32'(ack_i), 32'h0);
        en_mask = 8'h40;
        tick();
        chk("elig_req_o", 32'(req_o), 32'h40);
        wait_ack(1'b1, "elig");
        pop_chk("elig_grant");
        req_i = 1'b0;
        wait_ack(1'b0, "elig_rel");
        en_mask = 8'hFF;

        // Ack on the final count cycle wins over timeout.
        manual = 1'b1;
        ack_o  = 8'h00;
        push_exp(3'd7);
        req_i = 1'b1;
        tick();
        tick();
        chk("last_req_o", 32'(req_o), 32'h80);
        repeat (15) tick();
        chk("last_req_hold", 32'(req_o), 32'h80);
        ack_o = 8'h80;
        tick();
        chk("last_ack_i", 32'(ack_i), 32'h1);
        chk("last_req_low", 32'(req_o), 32'h0);
        chk("last_dead", 32'(dead), 32'h08);
        pop_chk("last_grant");
        ack_o = 8'h00;
        req_i = 1'b0;
        wait_ack(1'b0, "last_rel");
        manual = 1'b0;

        clr_dead = 1'b1;
        tick();
        clr_dead = 1'b0;
        chk("clr_dead", 32'(dead), 32'h0);

        // Kill targets 0 and 7, then reopen the mask so target 1 serves.
        en_mask = 8'h81;
        resp_en = 8'h7E;
        push_exp(3'd1);
        req_i = 1'b1;
        wait_dead(8'h81, "kill");
        repeat (3) tick();
        chk("kill_stuck_req_o", 32'(req_o), 32'h0);
        chk("kill_stuck_busy", 32'(busy), 32'h1);
        en_mask = 8'hFF;
        wait_ack(1'b1, "kill_retry");
        pop_chk("kill_grant");
        req_i = 1'b0;
        wait_ack(1'b0, "kill_rel");
        chk("kill_dead_keep", 32'(dead), 32'h81);

        // clr_dead coincident with timeout on target 2 leaves only bit 2.
        resp_en = 8'h7A;
        push_exp(3'd3);
        req_i = 1'b1;
        wait_req(8'h04, "clrt");
        repeat (15) tick();
        clr_dead = 1'b1;
        tick();
        clr_dead = 1'b0;
        chk("clrt_dead", 32'(dead), 32'h04);
        wait_ack(1'b1, "clrt_retry");
        pop_chk("clrt_grant");
        req_i = 1'b0;
        wait_ack(1'b0, "clrt_rel");
        resp_en = 8'hFF;

        // Reset while in DONE aborts the transaction.
        push_exp(3'd4);
        req_i = 1'b1;
        wait_ack(1'b1, "rstd");
        pop_chk("rstd_grant");
        rst = 1'b1;
        tick();
        chk("rstd_ack_i", 32'(ack_i), 32'h0);
        chk("rstd_req_o", 32'(req_o), 32'h0);
        chk("rstd_dead", 32'(dead), 32'h0);
        chk("rstd_grant_idx", 32'(grant_idx), 32'h0);
        chk("rstd_busy", 32'(busy), 32'h0);
        rst   = 1'b0;
        req_i = 1'b0;
        tick();
        txn(3'd0, "post_rst");

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
